// File: rtl/parser_pkg.sv
// Shared definitions for parser-family blocks: flit width, frame codes, FSM states.
package parser_pkg;

  localparam int DATA_W = 134;

  typedef enum logic [1:0] {
    META_END = 2'b00,
    HEAD     = 2'b01,
    TAIL     = 2'b10,
    BODY     = 2'b11
  } frame_code_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FWD  = 2'b01,
    HOLD = 2'b10
  } parser_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on contention the port other than `last` wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/parser_in_arbiter.sv
// Two-port packet arbiter in front of the parser; forwards whole packets with a holdoff gap.
//
// state | meaning
// IDLE  | waiting for a head; non-head flits are accepted and dropped
// FWD   | forwarding the granted port's packet until its tail
// HOLD  | holdoff countdown, then wait for parser_ready
module parser_in_arbiter #(
  parameter int DATA_W  = 134,
  parameter int HOLDOFF = 2,
  parameter int ERR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  output logic              in1_ready,
  input  logic              parser_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       pkt_cnt0,
  output logic [15:0]       pkt_cnt1,
  output logic [ERR_W-1:0]  gap_err_cnt,
  output logic [ERR_W-1:0]  frame_err_cnt
);
  import parser_pkg::*;

  localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

  parser_state_e     state_q;
  logic              last_grant;
  logic              grant_port;
  logic [HW-1:0]     hold_cnt;

  logic [1:0]        code0, code1, sel_code;
  logic              elig0, elig1, drop0, drop1;
  logic [1:0]        gnt;
  logic              sel_valid;
  logic [DATA_W-1:0] sel_data;
  logic [1:0]        frame_inc;
  logic              gap_inc;
  logic [ERR_W:0]    frame_sum, gap_sum;

  assign code0     = in0_data[DATA_W-1 -: 2];
  assign code1     = in1_data[DATA_W-1 -: 2];
  assign elig0     = parser_ready && in0_valid && (code0 == HEAD);
  assign elig1     = parser_ready && in1_valid && (code1 == HEAD);
  assign drop0     = in0_valid && (code0 != HEAD);
  assign drop1     = in1_valid && (code1 != HEAD);
  assign sel_valid = grant_port ? in1_valid : in0_valid;
  assign sel_data  = grant_port ? in1_data : in0_data;
  assign sel_code  = grant_port ? code1 : code0;

  rr_pick2 u_rr_pick2 (
    .req  ({elig1, elig0}),
    .last (last_grant),
    .gnt  (gnt)
  );

  always_comb begin
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    frame_inc = 2'd0;
    gap_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        in0_ready = gnt[0] | drop0;
        in1_ready = gnt[1] | drop1;
        frame_inc = {1'b0, drop0} + {1'b0, drop1};
      end
      FWD: begin
        in0_ready = ~grant_port;
        in1_ready = grant_port;
        gap_inc   = ~sel_valid;
        frame_inc = {1'b0, sel_valid && (sel_code == HEAD || sel_code == META_END)};
      end
      default: ;
    endcase
  end

  // Error counters stick at all-ones instead of wrapping.
  assign frame_sum = {1'b0, frame_err_cnt} + (ERR_W+1)'(frame_inc);
  assign gap_sum   = {1'b0, gap_err_cnt} + (ERR_W+1)'(gap_inc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      last_grant    <= 1'b1;
      grant_port    <= 1'b0;
      hold_cnt      <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      pkt_cnt0      <= '0;
      pkt_cnt1      <= '0;
      gap_err_cnt   <= '0;
      frame_err_cnt <= '0;
    end else begin
      out_valid     <= 1'b0;
      frame_err_cnt <= frame_sum[ERR_W] ? '1 : frame_sum[ERR_W-1:0];
      gap_err_cnt   <= gap_sum[ERR_W] ? '1 : gap_sum[ERR_W-1:0];
      case (state_q)
        IDLE: begin
          if (|gnt) begin
            out_valid  <= 1'b1;
            out_data   <= gnt[1] ? in1_data : in0_data;
            grant_port <= gnt[1];
            state_q    <= FWD;
          end
        end
        FWD: begin
          if (sel_valid && (sel_code == BODY || sel_code == TAIL)) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
          end
          if (sel_valid && sel_code == TAIL) begin
            if (grant_port) pkt_cnt1 <= pkt_cnt1 + 16'd1;
            else            pkt_cnt0 <= pkt_cnt0 + 16'd1;
            last_grant <= grant_port;
            hold_cnt   <= HW'(HOLDOFF);
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt != '0)   hold_cnt <= hold_cnt - 1'b1;
          else if (parser_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parser_in_arbiter.sv
// Scoreboard bench for parser_in_arbiter: expected flits are queued with their due cycle.
module tb_parser_in_arbiter;

  localparam logic [1:0] C_HEAD = 2'b01;
  localparam logic [1:0] C_BODY = 2'b11;
  localparam logic [1:0] C_TAIL = 2'b10;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in0_valid = 1'b0, in1_valid = 1'b0;
  logic [133:0] in0_data = '0, in1_data = '0;
  logic         in0_ready, in1_ready;
  logic         parser_ready = 1'b0;
  logic         out_valid;
  logic [133:0] out_data;
  logic [15:0]  pkt_cnt0, pkt_cnt1;
  logic [7:0]   gap_err_cnt, frame_err_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [133:0] data;
    int           due;
  } sb_t;
  sb_t sb[$];

  always #5 clk = ~clk;

  parser_in_arbiter #(.DATA_W(134), .HOLDOFF(2), .ERR_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .in0_valid     (in0_valid),
    .in0_data      (in0_data),
    .in0_ready     (in0_ready),
    .in1_valid     (in1_valid),
    .in1_data      (in1_data),
    .in1_ready     (in1_ready),
    .parser_ready  (parser_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .pkt_cnt0      (pkt_cnt0),
    .pkt_cnt1      (pkt_cnt1),
    .gap_err_cnt   (gap_err_cnt),
    .frame_err_cnt (frame_err_cnt)
  );

  // Output monitor: every out_valid must match the queue head due this cycle.
  always @(negedge clk) begin
    cyc++;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      checks++; errors++;
      $display("FAIL sb_missing: flit due cycle %0d never appeared", sb[0].due);
      void'(sb.pop_front());
    end
    if (out_valid) begin
      checks++;
      if (sb.size() == 0 || sb[0].due != cyc) begin
        errors++;
        $display("FAIL sb_unexpected: out_valid=1 at cycle %0d data=%h, required no output", cyc, out_data);
      end else begin
        if (out_data !== sb[0].data) begin
          errors++;
          $display("FAIL sb_data: got %h required %h", out_data, sb[0].data);
        end
        void'(sb.pop_front());
      end
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      checks++; errors++;
      $display("FAIL sb_missing: out_valid=0 at cycle %0d, required %h", cyc, sb[0].data);
      void'(sb.pop_front());
    end
  end

  function automatic logic [133:0] mk(input logic [1:0] c);
    return {c, 4'h0, $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One cycle: drive inputs, check readys, queue forwarded flits.
  task automatic step(input logic v0, input logic [1:0] c0, input logic v1, input logic [1:0] c1,
                      input logic pr, input logic er0, input logic er1,
                      input logic f0, input logic f1, input string nm);
    logic [133:0] d0, d1;
    d0 = mk(c0);
    d1 = mk(c1);
    in0_valid = v0; in0_data = d0;
    in1_valid = v1; in1_data = d1;
    parser_ready = pr;
    #1;
    checks++;
    if (in0_ready !== er0 || in1_ready !== er1) begin
      errors++;
      $display("FAIL %s ready: got r0=%b r1=%b required r0=%b r1=%b", nm, in0_ready, in1_ready, er0, er1);
    end
    if (f0) sb.push_back('{d0, cyc + 1});
    if (f1) sb.push_back('{d1, cyc + 1});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 2'b00, 0, 2'b00, 1, 0, 0, 0, 0, "idle");
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    in0_valid = 0; in1_valid = 0; parser_ready = 0;
    sb.delete();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || pkt_cnt0 !== 16'd0 || pkt_cnt1 !== 16'd0 ||
        gap_err_cnt !== 8'd0 || frame_err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: got ov=%b od=%h p0=%0d p1=%0d gap=%0d frm=%0d required all zero",
               out_valid, out_data, pkt_cnt0, pkt_cnt1, gap_err_cnt, frame_err_cnt);
    end
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    step(0, 2'b00, 0, 2'b00, 1, 0, 0, 0, 0, "reset_idle");
  endtask

  task automatic test_single_packet();
    do_reset();
    step(1, C_HEAD, 0, 2'b00, 1, 1, 0, 1, 0, "single_head");
    step(1, C_BODY, 0, 2'b00, 1, 1, 0, 1, 0, "single_body1");
    step(1, C_BODY, 0, 2'b00, 1, 1, 0, 1, 0, "single_body2");
    step(1, C_TAIL, 0, 2'b00, 1, 1, 0, 1, 0, "single_tail");
    idle(3);
    checks++;
    if (pkt_cnt0 !== 16'd1 || pkt_cnt1 !== 16'd0) begin
      errors++;
      $display("FAIL single_pkt_cnt: got p0=%0d p1=%0d required p0=1 p1=0", pkt_cnt0, pkt_cnt1);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    step(1, C_HEAD, 1, C_HEAD, 1, 1, 0, 1, 0, "rr_both_head");
    step(1, C_BODY, 1, C_HEAD, 1, 1, 0, 1, 0, "rr_p0_body");
    step(1, C_TAIL, 1, C_HEAD, 1, 1, 0, 1, 0, "rr_p0_tail");
    for (int i = 0; i < 3; i++) step(0, 2'b00, 1, C_HEAD, 1, 0, 0, 0, 0, "rr_hold");
    step(0, 2'b00, 1, C_HEAD, 1, 0, 1, 0, 1, "rr_p1_head");
    step(1, C_HEAD, 1, C_TAIL, 1, 0, 1, 0, 1, "rr_p1_tail");
    for (int i = 0; i < 3; i++) step(1, C_HEAD, 1, C_HEAD, 1, 0, 0, 0, 0, "rr_hold2");
    step(1, C_HEAD, 1, C_HEAD, 1, 1, 0, 1, 0, "rr_both_again");
    step(1, C_TAIL, 1, C_HEAD, 1, 1, 0, 1, 0, "rr_p0_tail2");
    idle(3);
    checks++;
    if (pkt_cnt0 !== 16'd2 || pkt_cnt1 !== 16'd1) begin
      errors++;
      $display("FAIL rr_pkt_cnt: got p0=%0d p1=%0d required p0=2 p1=1", pkt_cnt0, pkt_cnt1);
    end
  endtask

  task automatic test_gap();
    do_reset();
    step(0, 2'b00, 1, C_HEAD, 1, 0, 1, 0, 1, "gap_head");
    step(0, 2'b00, 1, C_BODY, 1, 0, 1, 0, 1, "gap_body");
    for (int i = 0; i < 3; i++) step(1, C_HEAD, 0, 2'b00, 0, 0, 1, 0, 0, "gap_bubble");
    step(0, 2'b00, 1, C_TAIL, 1, 0, 1, 0, 1, "gap_tail");
    idle(3);
    checks++;
    if (gap_err_cnt !== 8'd3 || pkt_cnt1 !== 16'd1 || frame_err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL gap_counts: got gap=%0d p1=%0d frm=%0d required gap=3 p1=1 frm=0",
               gap_err_cnt, pkt_cnt1, frame_err_cnt);
    end
  endtask

  task automatic test_frame_err();
    do_reset();
    step(1, C_BODY, 0, 2'b00, 1, 1, 0, 0, 0, "frm_idle_body");
    checks++;
    if (frame_err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL frm_one: got %0d required 1", frame_err_cnt);
    end
    for (int i = 0; i < 299; i++) step(1, C_BODY, 0, 2'b00, 1, 1, 0, 0, 0, "frm_flood");
    checks++;
    if (frame_err_cnt !== 8'd255) begin
      errors++;
      $display("FAIL frm_saturate: got %0d required 255", frame_err_cnt);
    end
    do_reset();
    step(1, C_HEAD, 0, 2'b00, 1, 1, 0, 1, 0, "frm_head");
    step(1, C_HEAD, 1, C_BODY, 1, 1, 0, 0, 0, "frm_head_in_fwd");
    step(1, C_TAIL, 0, 2'b00, 1, 1, 0, 1, 0, "frm_tail");
    idle(3);
    checks++;
    if (frame_err_cnt !== 8'd1 || pkt_cnt0 !== 16'd1) begin
      errors++;
      $display("FAIL frm_fwd_head: got frm=%0d p0=%0d required frm=1 p0=1", frame_err_cnt, pkt_cnt0);
    end
  endtask

  task automatic test_parser_ready();
    do_reset();
    for (int i = 0; i < 3; i++) step(1, C_HEAD, 0, 2'b00, 0, 0, 0, 0, 0, "pr_blocked");
    step(1, C_HEAD, 0, 2'b00, 1, 1, 0, 1, 0, "pr_head");
    step(1, C_TAIL, 0, 2'b00, 0, 1, 0, 1, 0, "pr_tail_ignored");
    for (int i = 0; i < 5; i++) step(0, 2'b00, 1, C_HEAD, 0, 0, 0, 0, 0, "pr_hold_wait");
    step(0, 2'b00, 1, C_HEAD, 1, 0, 0, 0, 0, "pr_hold_exit");
    step(0, 2'b00, 1, C_HEAD, 1, 0, 1, 0, 1, "pr_p1_head");
    step(0, 2'b00, 1, C_TAIL, 0, 0, 1, 0, 1, "pr_p1_tail");
    idle(3);
    checks++;
    if (pkt_cnt0 !== 16'd1 || pkt_cnt1 !== 16'd1) begin
      errors++;
      $display("FAIL pr_pkt_cnt: got p0=%0d p1=%0d required p0=1 p1=1", pkt_cnt0, pkt_cnt1);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    step(1, C_BODY, 0, 2'b00, 1, 1, 0, 0, 0, "mid_drop");
    step(1, C_HEAD, 0, 2'b00, 1, 1, 0, 1, 0, "mid_pkt_head");
    step(1, C_TAIL, 0, 2'b00, 1, 1, 0, 1, 0, "mid_pkt_tail");
    idle(3);
    checks++;
    if (pkt_cnt0 !== 16'd1 || frame_err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL mid_pre: got p0=%0d frm=%0d required p0=1 frm=1", pkt_cnt0, frame_err_cnt);
    end
    step(1, C_HEAD, 0, 2'b00, 1, 1, 0, 1, 0, "mid_head");
    step(1, C_BODY, 0, 2'b00, 1, 1, 0, 1, 0, "mid_body");
    do_reset();
    step(0, 2'b00, 1, C_HEAD, 1, 0, 1, 0, 1, "mid_new_head");
    step(0, 2'b00, 1, C_TAIL, 1, 0, 1, 0, 1, "mid_new_tail");
    idle(3);
    checks++;
    if (pkt_cnt0 !== 16'd0 || pkt_cnt1 !== 16'd1) begin
      errors++;
      $display("FAIL mid_post: got p0=%0d p1=%0d required p0=0 p1=1", pkt_cnt0, pkt_cnt1);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_packet();
    test_round_robin();
    test_gap();
    test_frame_err();
    test_parser_ready();
    test_reset_mid_packet();
    idle(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d flits still expected, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/parser_in_arbiter.md
PARSER_IN_ARBITER -- requirements
Module: parser_in_arbiter

Interface
REQ-001 Parameter DATA_W, default 134, flit width: [133:132] frame code, [127:0] payload.
REQ-002 Parameter HOLDOFF, default 2, minimum idle cycles between a forwarded tail and the next grant.
REQ-003 Parameter ERR_W, default 8, width of the error counters.
REQ-004 Port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1, asynchronous, active-low reset.
REQ-006 Ports in0_valid / in1_valid, input, 1, a requester flit is present.
REQ-007 Ports in0_data / in1_data, input, DATA_W, requester flit.
REQ-008 Ports in0_ready / in1_ready, output, 1, flit accepted this cycle when valid&ready (combinational from state and inputs).
REQ-009 Port parser_ready, input, 1, the parser's ready_out; high means a new packet head may be presented.
REQ-010 Port out_valid, output, 1, flit valid toward the parser's metadata_in_valid.
REQ-011 Port out_data, output, DATA_W, flit toward the parser's metadata_in.
REQ-012 Ports pkt_cnt0 / pkt_cnt1, output, 16, packets forwarded per port, wrapping.
REQ-013 Port gap_err_cnt, output, ERR_W, saturating count of mid-packet valid-gap cycles.
REQ-014 Port frame_err_cnt, output, ERR_W, saturating count of dropped misframed flits.

Function
REQ-015 Frame codes SHALL be 01 head, 11 body, 10 tail; packets SHALL be at least 2 flits.
REQ-016 The FSM SHALL have states IDLE, FWD, HOLD.
REQ-017 In IDLE with parser_ready=1, a port whose valid=1 and code=01 SHALL be eligible; the arbiter SHALL assert ready to exactly one eligible port and go to FWD.
REQ-018 When both ports are eligible, the grant SHALL go to the port other than last_grant (round robin); last_grant resets to 1, so port 0 wins first.
REQ-019 In IDLE, a valid non-head flit SHALL be accepted (ready=1), dropped and counted in frame_err_cnt; with parser_ready=0 no head SHALL be accepted.
REQ-020 An accepted flit SHALL appear on out_data with out_valid=1 exactly 1 cycle later; out_valid SHALL otherwise be 0.
REQ-021 In FWD, only the granted port's ready SHALL be 1; the other port's ready SHALL be 0.
REQ-022 In FWD, a cycle with granted valid=0 SHALL produce out_valid=0 next cycle and increment gap_err_cnt.
REQ-023 In FWD, a head flit (01) from the granted port SHALL be accepted, dropped and counted in frame_err_cnt; the packet continues.
REQ-024 Accepting a tail (10) in FWD SHALL increment the granted port's pkt_cnt, update last_grant, load the holdoff counter with HOLDOFF and go to HOLD.
REQ-025 In HOLD, both readys SHALL be 0; the counter SHALL decrement to 0, and the FSM SHALL return to IDLE only when the counter is 0 and parser_ready=1.
REQ-026 Error counters SHALL saturate at all-ones; pkt_cnt SHALL wrap from 0xFFFF to 0.
REQ-027 parser_ready SHALL be ignored in FWD; the packet is never split.

Reset
REQ-028 Reset SHALL force state IDLE, last_grant=1, out_valid=0, out_data=0, all counters=0 and the holdoff counter=0.
REQ-029 Reset mid-packet SHALL abandon the packet silently; no tail is synthesised.
REQ-030 After reset release, readys SHALL follow REQ-017 on the first cycle.

Structure
REQ-031 Shared package parser_pkg SHALL hold DATA_W, the frame codes (HEAD, BODY, TAIL, META_END=00) and the FSM state encodings used by parser-family blocks.
REQ-032 The two-way round-robin pick SHALL be a sub-module rr_pick2 (inputs req[1:0], last; output one-hot gnt).
REQ-033 The arbiter SHALL contain no packet storage; buffering stays in the parser.

Verification
REQ-034 Port0 sends a 4-flit packet (01,11,11,10) with parser_ready=1 -> the same 4 flits on out_data, 1-cycle latency, pkt_cnt0=1, in1_ready=0 throughout.
REQ-035 Both ports present heads in the same cycle after reset -> port0 is forwarded first, then port1 after HOLD; with HOLDOFF=2, at least 2 idle out_valid cycles separate the packets.
REQ-036 Port1 drops valid for 3 cycles mid-packet -> 3 out_valid=0 bubbles, gap_err_cnt=3, tail still forwarded and pkt_cnt1=1.
REQ-037 A body flit (11) arrives in IDLE -> it is dropped, frame_err_cnt=1, out_valid stays 0; 300 such flits -> frame_err_cnt=255.
REQ-038 parser_ready is held 0 with a head waiting -> both readys are 0 and no output; parser_ready rises -> the head is forwarded 1 cycle after acceptance.
REQ-039 Reset is asserted after 2 flits of a packet -> out_valid=0 and all counters 0 immediately; a new packet after release is forwarded normally.
